// File: rtl/frame_pkg.sv
// rtl/frame_pkg.sv - shared types and constants for the framebuffer read path
package frame_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN,
    DONE
  } frame_state_t;

  localparam int PIX_W       = 24;
  localparam int ADDR_STRIDE = 4;

endpackage

// File: rtl/pixel_fifo.sv
// rtl/pixel_fifo.sv - synchronous pixel FIFO with occupancy count
module pixel_fifo #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       count;
  logic              do_push;
  logic              do_pop;

  // Flags come straight from the count register so callers never see a
  // combinational path from push/pop back into full/empty.
  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = empty ? '0 : mem[rd_ptr];

  // Pointer and occupancy bookkeeping; reset flushes the queue.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      if (do_push && !do_pop)      count <= count + CNT_ONE;
      else if (do_pop && !do_push) count <= count - CNT_ONE;
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/frame_reader.sv
// rtl/frame_reader.sv - raster-order framebuffer reader feeding a pixel stream
module frame_reader
  import frame_pkg::*;
#(
  parameter int               ASIZE  = 32,
  parameter logic [ASIZE-1:0] START  = ASIZE'('h0800_0000),
  parameter int               WIDTH  = 640,
  parameter int               HEIGHT = 480,
  parameter int               DEPTH  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [ASIZE-1:0] address,
  output logic             ren,
  input  logic [31:0]      rdata,
  input  logic             buswait,
  output logic [23:0]      pix_data,
  output logic             pix_valid,
  input  logic             pix_ready,
  output logic [9:0]       pix_x,
  output logic [8:0]       pix_y,
  output logic             busy,
  output logic             frame_done
);

  localparam logic [18:0]      LAST_RD = 19'(WIDTH * HEIGHT - 1);
  localparam logic [9:0]       X_LAST  = 10'(WIDTH - 1);
  localparam logic [8:0]       Y_LAST  = 9'(HEIGHT - 1);
  localparam logic [ASIZE-1:0] STRIDE  = ASIZE'(ADDR_STRIDE);

  frame_state_t state, state_nxt;
  logic [18:0]  rd_cnt;
  logic         fifo_full;
  logic         fifo_empty;
  logic         rd_done;
  logic         pop;
  logic         unused_rdata_hi;

  assign rd_done         = ren && !buswait;
  assign pix_valid       = !fifo_empty;
  assign pop             = pix_valid && pix_ready;
  assign busy            = (state != IDLE);
  assign unused_rdata_hi = ^rdata[31:24];

  pixel_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (PIX_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (rd_done),
    .pop   (pop),
    .din   (rdata[PIX_W-1:0]),
    .dout  (pix_data),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state and bus request; ren never looks at buswait so a request,
  // once raised, stays up until it completes.
  always_comb begin
    state_nxt  = state;
    ren        = 1'b0;
    frame_done = 1'b0;
    case (state)
      IDLE:  if (start) state_nxt = FETCH;
      FETCH: begin
        ren = !fifo_full;
        if (ren && !buswait && rd_cnt == LAST_RD) state_nxt = DRAIN;
      end
      DRAIN: if (fifo_empty) state_nxt = DONE;
      DONE: begin
        frame_done = 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Read address walks the buffer by one word per completed read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      address <= START;
      rd_cnt  <= '0;
    end else if (state == IDLE && start) begin
      address <= START;
      rd_cnt  <= '0;
    end else if (rd_done) begin
      address <= address + STRIDE;
      rd_cnt  <= rd_cnt + 19'd1;
    end
  end

  // Screen coordinates of the head pixel advance on each accepted pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pix_x <= '0;
      pix_y <= '0;
    end else if (pop) begin
      if (pix_x == X_LAST) begin
        pix_x <= '0;
        pix_y <= (pix_y == Y_LAST) ? '0 : pix_y + 9'd1;
      end else begin
        pix_x <= pix_x + 10'd1;
      end
    end
  end

endmodule

// File: tb/tb_frame_reader.sv
// tb/tb_frame_reader.sv - directed self-checking bench for frame_reader
module tb_frame_reader;

  localparam logic [31:0] START = 32'h0800_0000;
  localparam int W     = 4;
  localparam int H     = 4;
  localparam int NPIX  = W * H;
  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] address;
  logic        ren;
  logic [31:0] rdata;
  logic        buswait;
  logic [23:0] pix_data;
  logic        pix_valid;
  logic        pix_ready;
  logic [9:0]  pix_x;
  logic [8:0]  pix_y;
  logic        busy;
  logic        frame_done;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  logic [31:0] rd_q   [$];
  logic [42:0] pop_q  [$];
  int          done_q [$];

  always #5 clk = ~clk;

  // Memory model: each word holds a scrambled copy of its own address.
  assign rdata = {8'hC3, address[23:0] ^ 24'h5A5A5A};

  frame_reader #(
    .ASIZE  (32),
    .START  (START),
    .WIDTH  (W),
    .HEIGHT (H),
    .DEPTH  (DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .address    (address),
    .ren        (ren),
    .rdata      (rdata),
    .buswait    (buswait),
    .pix_data   (pix_data),
    .pix_valid  (pix_valid),
    .pix_ready  (pix_ready),
    .pix_x      (pix_x),
    .pix_y      (pix_y),
    .busy       (busy),
    .frame_done (frame_done)
  );

  // Bus and stream monitor: records completed reads, pops and done pulses.
  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      if (ren && !buswait) rd_q.push_back(address);
      if (pix_valid && pix_ready) pop_q.push_back({pix_y, pix_x, pix_data});
      if (frame_done) done_q.push_back(cyc);
    end
  end

  function automatic logic [31:0] exp_addr(input int i);
    return START + 32'(4 * i);
  endfunction

  function automatic logic [42:0] exp_pop(input int i);
    logic [31:0] a;
    a = exp_addr(i);
    return {9'(i / W), 10'(i % W), a[23:0] ^ 24'h5A5A5A};
  endfunction

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic look();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_logs();
    rd_q.delete();
    pop_q.delete();
    done_q.delete();
  endtask

  task automatic wait_done(input int max_cyc, output int dc, output bit ok);
    ok = 1'b0;
    dc = -1;
    for (int i = 0; i < max_cyc; i++) begin
      if (done_q.size() > 0) begin
        dc = done_q[0];
        ok = 1'b1;
        return;
      end
      step();
      look();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; buswait = 1'b0; pix_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
    look();
    n_cmp++; if (address !== START) begin n_bad++; $display("FAIL reset_address got %0h want %0h", address, START); end
    n_cmp++; if (ren !== 1'b0) begin n_bad++; $display("FAIL reset_ren got %0b want 0", ren); end
    n_cmp++; if (pix_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %0b want 0", pix_valid); end
    n_cmp++; if (pix_data !== 24'h0) begin n_bad++; $display("FAIL reset_data got %0h want 0", pix_data); end
    n_cmp++; if ({pix_y, pix_x} !== 19'h0) begin n_bad++; $display("FAIL reset_xy got %0d,%0d want 0,0", pix_x, pix_y); end
    n_cmp++; if ({busy, frame_done} !== 2'b00) begin n_bad++; $display("FAIL reset_busy_done got %b want 00", {busy, frame_done}); end
  endtask

  task automatic test_basic();
    int  n, dc;
    bit  ok;
    step();
    clear_logs();
    pix_ready = 1'b1; buswait = 1'b0; start = 1'b1;
    n = cyc + 1;
    look();
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL basic_busy_n got %0b want 0", busy); end
    step(); start = 1'b0; look();
    n_cmp++; if ({busy, ren, pix_valid} !== 3'b110) begin n_bad++; $display("FAIL basic_n1 got %b want 110", {busy, ren, pix_valid}); end
    n_cmp++; if (address !== START) begin n_bad++; $display("FAIL basic_addr_n1 got %0h want %0h", address, START); end
    step(); look();
    n_cmp++; if (pix_valid !== 1'b1) begin n_bad++; $display("FAIL basic_valid_n2 got %0b want 1", pix_valid); end
    n_cmp++; if (address !== START + 32'd4) begin n_bad++; $display("FAIL basic_addr_n2 got %0h want %0h", address, START + 32'd4); end
    wait_done(60, dc, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL basic_timeout got no frame_done want one"); end
    n_cmp++; if (dc !== n + NPIX + 3) begin n_bad++; $display("FAIL basic_done_cycle got %0d want %0d", dc - n, NPIX + 3); end
    n_cmp++; if ({pix_y, pix_x, pix_valid} !== 20'h0) begin n_bad++; $display("FAIL basic_end_xy got %0d,%0d v%0b want 0,0 v0", pix_x, pix_y, pix_valid); end
    step(); look();
    n_cmp++; if ({busy, frame_done} !== 2'b00) begin n_bad++; $display("FAIL basic_idle got %b want 00", {busy, frame_done}); end
    n_cmp++; if (done_q.size() != 1) begin n_bad++; $display("FAIL basic_ndone got %0d want 1", done_q.size()); end
    n_cmp++; if (rd_q.size() != NPIX) begin n_bad++; $display("FAIL basic_nreads got %0d want %0d", rd_q.size(), NPIX); end
    for (int i = 0; i < rd_q.size() && i < NPIX; i++) begin
      n_cmp++; if (rd_q[i] !== exp_addr(i)) begin n_bad++; $display("FAIL basic_read%0d got %0h want %0h", i, rd_q[i], exp_addr(i)); end
    end
    n_cmp++; if (pop_q.size() != NPIX) begin n_bad++; $display("FAIL basic_npops got %0d want %0d", pop_q.size(), NPIX); end
    for (int i = 0; i < pop_q.size() && i < NPIX; i++) begin
      n_cmp++; if (pop_q[i] !== exp_pop(i)) begin n_bad++; $display("FAIL basic_pop%0d got %0h want %0h", i, pop_q[i], exp_pop(i)); end
    end
  endtask

  task automatic test_buswait();
    int dc;
    bit ok;
    step();
    clear_logs();
    pix_ready = 1'b1; buswait = 1'b0; start = 1'b1;
    look();
    for (int k = 1; k <= 8; k++) begin
      step();
      start = 1'b0;
      buswait = (k >= 3 && k <= 5);
      look();
      if (k >= 3 && k <= 6) begin
        n_cmp++; if ({ren, address} !== {1'b1, START + 32'd8}) begin n_bad++; $display("FAIL stall_hold%0d got ren%0b %0h want ren1 %0h", k, ren, address, START + 32'd8); end
      end
    end
    buswait = 1'b0;
    wait_done(60, dc, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL stall_timeout got no frame_done want one"); end
    n_cmp++; if (rd_q.size() != NPIX) begin n_bad++; $display("FAIL stall_nreads got %0d want %0d", rd_q.size(), NPIX); end
    for (int i = 0; i < rd_q.size() && i < NPIX; i++) begin
      n_cmp++; if (rd_q[i] !== exp_addr(i)) begin n_bad++; $display("FAIL stall_read%0d got %0h want %0h", i, rd_q[i], exp_addr(i)); end
    end
    n_cmp++; if (pop_q.size() != NPIX) begin n_bad++; $display("FAIL stall_npops got %0d want %0d", pop_q.size(), NPIX); end
    for (int i = 0; i < pop_q.size() && i < NPIX; i++) begin
      n_cmp++; if (pop_q[i] !== exp_pop(i)) begin n_bad++; $display("FAIL stall_pop%0d got %0h want %0h", i, pop_q[i], exp_pop(i)); end
    end
  endtask

  task automatic test_fifo_full();
    int dc;
    bit ok;
    step();
    clear_logs();
    pix_ready = 1'b0; buswait = 1'b0; start = 1'b1;
    look();
    for (int k = 1; k <= 14; k++) begin
      step();
      start = 1'b0;
      pix_ready = (k >= 12);
      look();
      if (k == 9) begin
        n_cmp++; if ({ren, address} !== {1'b0, START + 32'd32}) begin n_bad++; $display("FAIL full_stop got ren%0b %0h want ren0 %0h", ren, address, START + 32'd32); end
        n_cmp++; if ({pix_valid, pix_x} !== {1'b1, 10'd0}) begin n_bad++; $display("FAIL full_head got v%0b x%0d want v1 x0", pix_valid, pix_x); end
      end
      if (k == 11) begin
        n_cmp++; if (rd_q.size() != DEPTH) begin n_bad++; $display("FAIL full_count got %0d want %0d", rd_q.size(), DEPTH); end
      end
      if (k == 12) begin
        n_cmp++; if (ren !== 1'b0) begin n_bad++; $display("FAIL full_pop_cycle_ren got %0b want 0", ren); end
      end
      if (k == 13) begin
        n_cmp++; if ({ren, address} !== {1'b1, START + 32'd32}) begin n_bad++; $display("FAIL full_resume got ren%0b %0h want ren1 %0h", ren, address, START + 32'd32); end
      end
    end
    wait_done(80, dc, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL full_timeout got no frame_done want one"); end
    n_cmp++; if (pop_q.size() != NPIX) begin n_bad++; $display("FAIL full_npops got %0d want %0d", pop_q.size(), NPIX); end
    for (int i = 0; i < pop_q.size() && i < NPIX; i++) begin
      n_cmp++; if (pop_q[i] !== exp_pop(i)) begin n_bad++; $display("FAIL full_pop%0d got %0h want %0h", i, pop_q[i], exp_pop(i)); end
    end
  endtask

  task automatic test_restart_reset();
    int dc;
    bit ok;
    step();
    clear_logs();
    pix_ready = 1'b1; buswait = 1'b0; start = 1'b1;
    look();
    for (int k = 1; k <= 6; k++) begin
      step();
      start = (k == 4);
      look();
    end
    start = 1'b0;
    wait_done(60, dc, ok);
    for (int k = 0; k < 25; k++) begin step(); look(); end
    n_cmp++; if (done_q.size() != 1) begin n_bad++; $display("FAIL restart_ndone got %0d want 1", done_q.size()); end
    n_cmp++; if (pop_q.size() != NPIX) begin n_bad++; $display("FAIL restart_npops got %0d want %0d", pop_q.size(), NPIX); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL restart_busy got %0b want 0", busy); end

    step();
    clear_logs();
    start = 1'b1;
    look();
    for (int k = 1; k <= 7; k++) begin
      step();
      start = 1'b0;
      if (k == 7) rst = 1'b1;
      look();
    end
    n_cmp++; if (pop_q.size() != 5) begin n_bad++; $display("FAIL rst_pops_before got %0d want 5", pop_q.size()); end
    n_cmp++; if ({address, ren, busy, pix_valid} !== {START, 3'b000}) begin n_bad++; $display("FAIL rst_mid got %0h r%0b b%0b v%0b want %0h 000", address, ren, busy, pix_valid, START); end
    n_cmp++; if ({pix_y, pix_x, pix_data} !== 43'h0) begin n_bad++; $display("FAIL rst_mid_pix got %0d,%0d %0h want 0,0 0", pix_x, pix_y, pix_data); end
    step();
    rst = 1'b0;
    look();
    for (int k = 0; k < 15; k++) begin step(); look(); end
    n_cmp++; if ({done_q.size() == 0, busy} !== 2'b10) begin n_bad++; $display("FAIL rst_no_done got ndone %0d busy %0b want 0 0", done_q.size(), busy); end

    step();
    clear_logs();
    start = 1'b1;
    look();
    step();
    start = 1'b0;
    look();
    n_cmp++; if ({ren, address} !== {1'b1, START}) begin n_bad++; $display("FAIL rst_restart got ren%0b %0h want ren1 %0h", ren, address, START); end
    wait_done(60, dc, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL rst_restart_timeout got no frame_done want one"); end
    n_cmp++; if (pop_q.size() != NPIX) begin n_bad++; $display("FAIL rst_restart_npops got %0d want %0d", pop_q.size(), NPIX); end
    for (int i = 0; i < pop_q.size() && i < NPIX; i++) begin
      n_cmp++; if (pop_q[i] !== exp_pop(i)) begin n_bad++; $display("FAIL rst_restart_pop%0d got %0h want %0h", i, pop_q[i], exp_pop(i)); end
    end
  endtask

  task automatic test_random_frames();
    for (int f = 0; f < 3; f++) begin
      step();
      clear_logs();
      buswait = 1'b0; pix_ready = 1'b1; start = 1'b1;
      look();
      for (int k = 0; k < 400 && done_q.size() == 0; k++) begin
        step();
        start = 1'b0;
        buswait = ($urandom_range(0, 2) == 0);
        pix_ready = ($urandom_range(0, 2) != 0);
        look();
      end
      buswait = 1'b0;
      pix_ready = 1'b1;
      n_cmp++; if (done_q.size() != 1) begin n_bad++; $display("FAIL rand%0d_ndone got %0d want 1", f, done_q.size()); end
      n_cmp++; if (rd_q.size() != NPIX) begin n_bad++; $display("FAIL rand%0d_nreads got %0d want %0d", f, rd_q.size(), NPIX); end
      for (int i = 0; i < rd_q.size() && i < NPIX; i++) begin
        n_cmp++; if (rd_q[i] !== exp_addr(i)) begin n_bad++; $display("FAIL rand%0d_read%0d got %0h want %0h", f, i, rd_q[i], exp_addr(i)); end
      end
      n_cmp++; if (pop_q.size() != NPIX) begin n_bad++; $display("FAIL rand%0d_npops got %0d want %0d", f, pop_q.size(), NPIX); end
      for (int i = 0; i < pop_q.size() && i < NPIX; i++) begin
        n_cmp++; if (pop_q[i] !== exp_pop(i)) begin n_bad++; $display("FAIL rand%0d_pop%0d got %0h want %0h", f, i, pop_q[i], exp_pop(i)); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_buswait();
    test_fifo_full();
    test_restart_reset();
    test_random_frames();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got no completion want finish before 500000");
    $fatal(1);
  end

endmodule
